// File: rtl/fc_argmax.sv
// fc_argmax: running argmax over one frame of NUM_CLASS signed scores from the fc layer.
// Optional score log enabled by defining FC_ARGMAX_SCORE_LOG_EN.
module fc_argmax #(
   parameter int NUM_CLASS = 10,
   parameter int IDX_W     = 4,
   parameter int DW        = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ivalid,
   input  logic [DW-1:0]    din,
   input  logic             frame_clr,
   output logic             ovalid,
   output logic [IDX_W-1:0] class_idx,
   output logic [DW-1:0]    max_score,
   output logic             busy,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [DW-1:0]    rd_data
);
   typedef enum logic {IDLE, ACC} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);
   state_t           state;
   logic [IDX_W-1:0] cnt, run_idx;
   logic [DW-1:0]    run_max;
   logic             gt;
   assign gt = $signed(din) > $signed(run_max);
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         run_max   <= '0;
         run_idx   <= '0;
         ovalid    <= 1'b0;
         class_idx <= '0;
         max_score <= '0;
         busy      <= 1'b0;
      end else begin
         ovalid <= 1'b0;
         if (frame_clr) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
         end else if (ivalid) begin
            if (state == IDLE) begin
               if (NUM_CLASS == 1) begin
                  class_idx <= '0;
                  max_score <= din;
                  ovalid    <= 1'b1;
               end else begin
                  run_max <= din;
                  run_idx <= '0;
                  cnt     <= IDX_W'(1);
                  state   <= ACC;
                  busy    <= 1'b1;
               end
            end else if (cnt == LAST) begin
               // last sample joins the compare on the finishing edge
               class_idx <= gt ? cnt : run_idx;
               max_score <= gt ? din : run_max;
               ovalid    <= 1'b1;
               state     <= IDLE;
               cnt       <= '0;
               busy      <= 1'b0;
            end else begin
               run_max <= gt ? din : run_max;
               run_idx <= gt ? cnt : run_idx;
               cnt     <= cnt + IDX_W'(1);
            end
         end
      end
`ifdef FC_ARGMAX_SCORE_LOG_EN
   logic [DW-1:0] log_mem [NUM_CLASS];
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         for (int i = 0; i < NUM_CLASS; i++) log_mem[i] <= '0;
      end else if (ivalid && !frame_clr) begin
         log_mem[cnt] <= din;
      end
   assign rd_data = ({1'b0, rd_addr} < (IDX_W + 1)'(NUM_CLASS)) ? log_mem[rd_addr] : '0;
`else
   logic unused_rd;
   assign unused_rd = ^rd_addr;
   assign rd_data   = '0;
`endif
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed table-driven bench for fc_argmax (NUM_CLASS=10, DW=32).
module tb_fc_argmax;
   logic        clk = 1'b0, rstn = 1'b0, ivalid = 1'b0, frame_clr = 1'b0;
   logic [31:0] din = '0;
   logic [3:0]  rd_addr = '0;
   logic        ovalid, busy;
   logic [3:0]  class_idx;
   logic [31:0] max_score, rd_data;
   int checks = 0, failures = 0;

   typedef struct {
      logic [9:0][31:0] s;
      bit               gap;
      logic [3:0]       idx;
      logic [31:0]      score;
   } vec_t;
   vec_t v[4];

   fc_argmax #(.NUM_CLASS(10), .IDX_W(4), .DW(32)) dut (
      .clk(clk), .rstn(rstn), .ivalid(ivalid), .din(din), .frame_clr(frame_clr),
      .ovalid(ovalid), .class_idx(class_idx), .max_score(max_score), .busy(busy),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [9:0][31:0] s, input bit gap, input logic [3:0] eidx,
                             input logic [31:0] escore);
      for (int i = 0; i < 10; i++) begin
         ivalid = 1'b1;
         din    = s[i];
         tick();
         if (i < 9) begin
            chk("no_early_ovalid", ovalid, 0);
            chk("busy_mid", busy, 1);
            if (gap) begin
               ivalid = 1'b0;
               tick();
               chk("no_ovalid_gap", ovalid, 0);
            end
         end
      end
      chk("ovalid", ovalid, 1);
      chk("class_idx", class_idx, eidx);
      chk("max_score", max_score, escore);
      chk("busy_end", busy, 0);
      ivalid = 1'b0;
      din    = '0;
      if (gap) begin
         tick();
         chk("single_pulse", ovalid, 0);
         chk("hold_idx", class_idx, eidx);
      end
   endtask

   initial begin
      int s2[10] = '{5, -3, 17, 2, 17, 0, 1, 1, 1, 1};
      logic [9:0][31:0] f1, f2, f5;
      for (int k = 0; k < 10; k++) begin
         v[0].s[k] = s2[k];
         v[1].s[k] = -100 + k;
         v[2].s[k] = 32'd7;
         v[3].s[k] = (k == 5) ? 32'h8000_0001 : 32'h8000_0000;
         f1[k] = 0;
         f2[k] = (k == 0) ? 32'h7FFF_FFFF : k - 1;
      end
      v[0].gap = 1; v[0].idx = 4'd2; v[0].score = 32'd17;
      v[1].gap = 0; v[1].idx = 4'd9; v[1].score = -32'sd91;
      v[2].gap = 1; v[2].idx = 4'd0; v[2].score = 32'd7;
      v[3].gap = 0; v[3].idx = 4'd5; v[3].score = 32'h8000_0001;
      f1 = {32'd3, 32'd5, 32'd6, 32'd2, 32'd9, 32'd5, 32'd1, 32'd4, 32'd1, 32'd3};
      f5 = {-32'sd1, 32'd42, 32'd42, 32'd3, 32'd41, 32'd0, -32'sd5, 32'd30, 32'd20, 32'd10};

      // reset held with ivalid toggling
      for (int i = 0; i < 6; i++) begin
         ivalid = i[0];
         din    = 32'd99;
         tick();
         chk("rst_ovalid", ovalid, 0);
         chk("rst_idx", class_idx, 0);
         chk("rst_score", max_score, 0);
         chk("rst_busy", busy, 0);
      end
      ivalid = 1'b0;
      rstn   = 1'b1;
      tick();

      for (int n = 0; n < 4; n++) send_frame(v[n].s, v[n].gap, v[n].idx, v[n].score);

      // async reset mid-frame
      for (int i = 0; i < 3; i++) begin
         ivalid = 1'b1;
         din    = 32'd1000 + i;
         tick();
      end
      chk("pre_rst_busy", busy, 1);
      #2 rstn = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_idx", class_idx, 0);
      chk("async_score", max_score, 0);
      ivalid = 1'b0;
      tick();
      chk("async_ovalid", ovalid, 0);
      rstn = 1'b1;
      tick();

      // back-to-back frames, continuous ivalid
      for (int i = 0; i < 20; i++) begin
         ivalid = 1'b1;
         din    = (i < 10) ? f1[i] : f2[i - 10];
         tick();
         chk("b2b_ovalid", ovalid, (i == 9 || i == 19));
         if (i == 9) begin
            chk("b2b_idx1", class_idx, 5);
            chk("b2b_score1", max_score, 9);
         end
         if (i == 14) chk("b2b_hold", class_idx, 5);
         if (i == 19) begin
            chk("b2b_idx2", class_idx, 0);
            chk("b2b_score2", max_score, 32'h7FFF_FFFF);
         end
      end
      ivalid = 1'b0;
      tick();
      chk("b2b_end", ovalid, 0);

      // partial frame aborted by frame_clr (with a colliding sample)
      for (int i = 0; i < 4; i++) begin
         ivalid = 1'b1;
         din    = 32'd100 * (i + 1);
         tick();
      end
      chk("clr_busy_before", busy, 1);
      frame_clr = 1'b1;
      din       = 32'd500;
      tick();
      frame_clr = 1'b0;
      ivalid    = 1'b0;
      chk("clr_busy_after", busy, 0);
      chk("clr_ovalid", ovalid, 0);
      chk("clr_keep_idx", class_idx, 0);
      chk("clr_keep_score", max_score, 32'h7FFF_FFFF);
      tick();
      chk("clr_no_pulse", ovalid, 0);
      send_frame(f5, 1'b1, 4'd7, 32'd42);

      // score log after the scenario-2 frame
      send_frame(v[0].s, 1'b1, 4'd2, 32'd17);
      rd_addr = 4'd4;
      #1;
`ifdef FC_ARGMAX_SCORE_LOG_EN
      chk("log4", rd_data, 32'd17);
      rd_addr = 4'd1;
      #1 chk("log1", rd_data, -32'sd3);
      rd_addr = 4'd12;
      #1 chk("log12", rd_data, 0);
`else
      chk("log4", rd_data, 0);
      rd_addr = 4'd1;
      #1 chk("log1", rd_data, 0);
      rd_addr = 4'd12;
      #1 chk("log12", rd_data, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
